// File: rtl/cgra_cfg_loader.sv
// cgra_cfg_loader: streams a CGRA configuration image from HBM over 4 KB-safe AXI read bursts
// into a 2-entry skid buffer feeding the configuration stream, then raises a sticky interrupt.
module cgra_cfg_loader #(
  parameter int dwidth_HBMadd = 64,
  parameter int phit_size     = 512,
  parameter int MAX_BURST     = 64,
  parameter int size_w        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [dwidth_HBMadd-1:0] ctrl_addr_offset,
  input  logic [size_w-1:0]        ctrl_xfer_size_in_bytes,
  input  logic                     intr_clr,
  output logic                     busy,
  output logic                     done,
  output logic                     interrupt,
  output logic                     err,
  output logic [dwidth_HBMadd-1:0] m00_axi_araddr,
  output logic [7:0]               m00_axi_arlen,
  output logic                     m00_axi_arvalid,
  input  logic                     m00_axi_arready,
  input  logic [phit_size-1:0]     m00_axi_rdata,
  input  logic                     m00_axi_rlast,
  input  logic                     m00_axi_rvalid,
  output logic                     m00_axi_rready,
  output logic [phit_size-1:0]     cfg_tdata,
  output logic                     cfg_tvalid,
  input  logic                     cfg_tready,
  output logic                     cfg_tlast
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, DONE} state_t;
  state_t state_q;
  logic [dwidth_HBMadd-1:0] addr_q;
  logic [size_w-1:0] rem_q, rem_d;
  logic [8:0] cnt_q, room, cap, beats;
  logic err_q, intr_q, wp_q, rp_q, push, pop;
  logic [1:0] occ_q, last_q;
  logic [phit_size-1:0] data_q [2];
  assign rem_d = size_w'(ctrl_xfer_size_in_bytes[size_w-1:6]) + size_w'(|ctrl_xfer_size_in_bytes[5:0]);
  // beats left before the next 4 KB page boundary
  assign room  = 9'd64 - 9'(addr_q[11:6]);
  assign cap   = (room < 9'(MAX_BURST)) ? room : 9'(MAX_BURST);
  assign beats = (rem_q < size_w'(cap)) ? rem_q[8:0] : cap;
  assign busy            = state_q != IDLE;
  assign done            = state_q == DONE;
  assign interrupt       = intr_q;
  assign err             = err_q;
  assign m00_axi_arvalid = state_q == ADDR;
  assign m00_axi_araddr  = (state_q == ADDR) ? addr_q : '0;
  assign m00_axi_arlen   = (state_q == ADDR) ? 8'(beats - 9'd1) : 8'd0;
  assign m00_axi_rready  = (state_q == DATA) && (occ_q != 2'd2);
  assign cfg_tvalid      = occ_q != 2'd0;
  assign cfg_tdata       = data_q[rp_q];
  assign cfg_tlast       = cfg_tvalid & last_q[rp_q];
  assign push            = m00_axi_rvalid & m00_axi_rready;
  assign pop             = cfg_tvalid & cfg_tready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      intr_q <= (state_q == DONE) | (intr_q & ~intr_clr);
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= ctrl_addr_offset & ~dwidth_HBMadd'(63);
          rem_q   <= rem_d;
          err_q   <= 1'b0;
          state_q <= (rem_d == '0) ? DONE : ADDR;
        end
        ADDR: if (m00_axi_arready) begin
          addr_q  <= addr_q + dwidth_HBMadd'({beats, 6'b0});
          rem_q   <= rem_q - size_w'(beats);
          cnt_q   <= beats;
          state_q <= DATA;
        end
        DATA: if (push) begin
          cnt_q <= cnt_q - 9'd1;
          // the beat count ends the burst; rlast only flags disagreement
          if (m00_axi_rlast != (cnt_q == 9'd1)) err_q <= 1'b1;
          if (cnt_q == 9'd1) state_q <= (rem_q != '0) ? ADDR : DRAIN;
        end
        DRAIN: if (occ_q == 2'd0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '{default: '0};
      last_q <= '0;
      occ_q  <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
    end else begin
      if (push) begin
        data_q[wp_q] <= m00_axi_rdata;
        last_q[wp_q] <= (cnt_q == 9'd1) && (rem_q == '0);
        wp_q         <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_cgra_cfg_loader.sv
// tb_cgra_cfg_loader: randomized AXI read slave and stream sink, checked against a burst/phit
// list computed directly from the transfer rules.
module tb_cgra_cfg_loader;
  localparam int AW = 64, PW = 512, MB = 64, SW = 32;
  typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [PW-1:0] data; logic last; } ph_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, intr_clr = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [SW-1:0] size_in = '0;
  logic busy, done, interrupt, err, arvalid, rready, tvalid, tlast;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [PW-1:0] tdata;
  logic arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, tready = 1'b0;
  logic [PW-1:0] rdata = '0;
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  int ar_pct = 100, r_pct = 100, t_pct = 100, t_hold = 0;
  int r_left = 0, r_idx = 0, r_len = 0, done_cnt = 0, done_cyc = 0, pop_cyc = 0, busy_fall = 0, beats_acc = 0;
  bit inj = 1'b0, r_hold = 1'b0, prev_arv = 1'b0, prev_busy = 1'b0;
  logic [63:0] r_addr = '0;
  logic [31:0] seed = '0;
  ar_t obs_ar[$], exp_ar[$];
  ph_t obs_out[$];
  logic [63:0] exp_beat[$];
  int ar_rise[$], last_beat[$];

  cgra_cfg_loader #(.dwidth_HBMadd(AW), .phit_size(PW), .MAX_BURST(MB), .size_w(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl_addr_offset(addr_in),
    .ctrl_xfer_size_in_bytes(size_in), .intr_clr(intr_clr), .busy(busy), .done(done),
    .interrupt(interrupt), .err(err), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready), .m00_axi_rdata(rdata),
    .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .cfg_tdata(tdata), .cfg_tvalid(tvalid), .cfg_tready(tready), .cfg_tlast(tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] beat_data(input logic [63:0] a);
    logic [31:0] w;
    w = (a[37:6] * 32'h9E37_79B1) ^ seed;
    return {8{w, w ^ 32'h5A5A_5A5A}};
  endfunction

  task automatic build_model(input logic [63:0] addr, input longint unsigned size);
    longint unsigned a, n, room, chunk;
    a = addr & ~64'd63;
    n = (size + 63) / 64;
    exp_ar.delete();
    exp_beat.delete();
    while (n > 0) begin
      room  = (4096 - (a % 4096)) / 64;
      chunk = (n < MB) ? n : MB;
      if (room < chunk) chunk = room;
      exp_ar.push_back(ar_t'{a, 8'(chunk - 1)});
      for (longint unsigned i = 0; i < chunk; i++) exp_beat.push_back(a + 64 * i);
      a += 64 * chunk;
      n -= chunk;
    end
  endtask

  // AXI read slave, stream sink and event recorder; inputs change at the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin r_left = 0; r_hold = 1'b0; rvalid = 1'b0; end
    arready = ($urandom_range(0, 99) < ar_pct);
    if (!r_hold) begin
      rvalid = (r_left > 0) && ($urandom_range(0, 99) < r_pct);
      rdata  = beat_data(r_addr + 64'(64 * r_idx));
      rlast  = (r_idx == r_len) ^ (inj && r_idx == 1);
    end
    if (t_hold > 0) begin tready = 1'b0; t_hold--; end
    else tready = ($urandom_range(0, 99) < t_pct);
    if (arvalid && !prev_arv) ar_rise.push_back(cyc);
    prev_arv = arvalid;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_busy = busy;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (arvalid && arready) begin
      obs_ar.push_back(ar_t'{araddr, arlen});
      r_addr = araddr; r_len = int'(arlen); r_left = r_len + 1; r_idx = 0;
    end
    r_hold = rvalid && !rready;
    if (rvalid && rready) begin
      beats_acc++; r_idx++; r_left--;
      if (r_left == 0) last_beat.push_back(cyc);
    end
    if (tvalid && tready) begin obs_out.push_back(ph_t'{tdata, tlast}); pop_cyc = cyc; end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [63:0] a, input logic [31:0] s);
    obs_ar.delete(); obs_out.delete(); ar_rise.delete(); last_beat.delete();
    done_cnt = 0; beats_acc = 0;
    seed = $urandom;
    build_model(a, 64'(s));
    step();
    addr_in = a; size_in = s; start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic finish_xfer(input string name, input bit exp_err);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) step();
    repeat (3) step();
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
    tests++;
    if (obs_ar.size() != exp_ar.size()) begin fails++; $display("FAIL %s ar_count: got %0d want %0d", name, obs_ar.size(), exp_ar.size()); end
    for (int i = 0; i < obs_ar.size() && i < exp_ar.size(); i++) begin
      tests++;
      if (obs_ar[i] !== exp_ar[i]) begin fails++; $display("FAIL %s ar[%0d]: got %h/%0d want %h/%0d", name, i, obs_ar[i].addr, obs_ar[i].len, exp_ar[i].addr, exp_ar[i].len); end
    end
    tests++;
    if (obs_out.size() != exp_beat.size()) begin fails++; $display("FAIL %s phit_count: got %0d want %0d", name, obs_out.size(), exp_beat.size()); end
    for (int i = 0; i < obs_out.size() && i < exp_beat.size(); i++) begin
      tests++;
      if (obs_out[i].data !== beat_data(exp_beat[i]) || obs_out[i].last !== (i == exp_beat.size() - 1)) begin
        fails++;
        $display("FAIL %s phit[%0d]: got %h last %b want %h last %b", name, i, obs_out[i].data[31:0], obs_out[i].last, beat_data(exp_beat[i]) & 512'hFFFF_FFFF, i == exp_beat.size() - 1);
      end
    end
    if (exp_beat.size() > 0) begin
      tests++;
      if (done_cyc - pop_cyc != 2) begin fails++; $display("FAIL %s done_after_pop: got %0d want 2", name, done_cyc - pop_cyc); end
    end
    tests++;
    if (busy !== 1'b0 || busy_fall != done_cyc + 1) begin fails++; $display("FAIL %s busy_fall: got busy %b at +%0d want 0 at +1", name, busy, busy_fall - done_cyc); end
    tests++;
    if (err !== exp_err) begin fails++; $display("FAIL %s err: got %b want %b", name, err, exp_err); end
    tests++;
    if (interrupt !== 1'b1) begin fails++; $display("FAIL %s interrupt_set: got %b want 1", name, interrupt); end
    step(); intr_clr = 1'b1;
    step(); intr_clr = 1'b0;
    tests++;
    if (interrupt !== 1'b0) begin fails++; $display("FAIL %s interrupt_clr: got %b want 0", name, interrupt); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    tests++;
    if ({busy, done, interrupt, err, arvalid, rready, tvalid, tlast} !== 8'b0) begin fails++; $display("FAIL reset_flags: got %b want 0", {busy, done, interrupt, err, arvalid, rready, tvalid, tlast}); end
    tests++;
    if (araddr !== '0 || arlen !== '0 || tdata !== '0) begin fails++; $display("FAIL reset_buses: got %h/%0d/%h want 0", araddr, arlen, tdata[31:0]); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_base();
    ar_pct = 100; r_pct = 100; t_pct = 100;
    launch(64'h1000, 256);
    tests++;
    if (busy !== 1'b1 || arvalid !== 1'b1 || araddr !== 64'h1000 || arlen !== 8'd3) begin
      fails++; $display("FAIL base_ar: got busy %b arvalid %b %h/%0d want 1 1 1000/3", busy, arvalid, araddr, arlen);
    end
    finish_xfer("base", 1'b0);
    tests++;
    if (obs_ar.size() != 1 || obs_ar[0] !== ar_t'{64'h1000, 8'd3}) begin fails++; $display("FAIL base_ar_list: got %0d entries want 1 at 1000/3", obs_ar.size()); end
  endtask

  task automatic test_multi();
    ar_pct = 50; r_pct = 70; t_pct = 80;
    launch(64'h0, 32'h1040);
    finish_xfer("multi", 1'b0);
    tests++;
    if (obs_ar.size() != 2 || obs_ar[0] !== ar_t'{64'h0, 8'd63} || obs_ar[1] !== ar_t'{64'h1000, 8'd0}) begin
      fails++; $display("FAIL multi_ar_list: got %0d entries want 0/63 then 1000/0", obs_ar.size());
    end
    tests++;
    if (ar_rise.size() < 2 || last_beat.size() < 1 || ar_rise[1] != last_beat[0] + 1) begin
      fails++; $display("FAIL multi_next_ar: got rise at %0d want %0d", ar_rise[1], last_beat[0] + 1);
    end
  endtask

  task automatic test_4k();
    ar_pct = 100; r_pct = 100; t_pct = 100;
    launch(64'h0FC0, 100);
    finish_xfer("split4k", 1'b0);
    tests++;
    if (obs_ar.size() != 2 || obs_ar[0] !== ar_t'{64'h0FC0, 8'd0} || obs_ar[1] !== ar_t'{64'h1000, 8'd0} || obs_out.size() != 2) begin
      fails++; $display("FAIL split4k_list: got %0d ars %0d phits want 2 2", obs_ar.size(), obs_out.size());
    end
  endtask

  task automatic test_backpressure();
    ar_pct = 100; r_pct = 100; t_pct = 100; t_hold = 12;
    launch(64'h2_0000, 512);
    repeat (6) step();
    tests++;
    if (rready !== 1'b0 || beats_acc != 2 || tvalid !== 1'b1) begin
      fails++; $display("FAIL bp_stall: got rready %b beats %0d tvalid %b want 0 2 1", rready, beats_acc, tvalid);
    end
    finish_xfer("backpressure", 1'b0);
  endtask

  task automatic test_zero();
    tests++;
    if (interrupt !== 1'b0) begin fails++; $display("FAIL zero_pre_intr: got %b want 0", interrupt); end
    launch(64'h40, 0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || arvalid !== 1'b0) begin fails++; $display("FAIL zero_done: got done %b busy %b arvalid %b want 1 1 0", done, busy, arvalid); end
    intr_clr = 1'b1;
    step();
    intr_clr = 1'b0;
    tests++;
    if (interrupt !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zero_collision: got intr %b done %b want 1 0", interrupt, done); end
    finish_xfer("zero", 1'b0);
  endtask

  task automatic test_start_busy();
    ar_pct = 80; r_pct = 60; t_pct = 70;
    launch(64'h5000, 640);
    for (int i = 0; i < 200 && beats_acc == 0; i++) step();
    addr_in = 64'h9000; size_in = 64; start = 1'b1;
    step();
    start = 1'b0;
    finish_xfer("start_busy", 1'b0);
  endtask

  task automatic test_err();
    ar_pct = 100; r_pct = 100; t_pct = 100; inj = 1'b1;
    launch(64'h2000, 256);
    finish_xfer("rlast_err", 1'b1);
    inj = 1'b0;
  endtask

  task automatic test_reset_mid();
    ar_pct = 100; r_pct = 100; t_pct = 100;
    launch(64'h3000, 1280);
    for (int i = 0; i < 100 && beats_acc < 3; i++) step();
    rst = 1'b0;
    step();
    tests++;
    if ({busy, done, interrupt, err, arvalid, rready, tvalid, tlast} !== 8'b0 || araddr !== '0 || arlen !== '0) begin
      fails++; $display("FAIL mid_reset: got flags %b addr %h len %0d want 0", {busy, done, interrupt, err, arvalid, rready, tvalid, tlast}, araddr, arlen);
    end
    rst = 1'b1;
    step();
    launch(64'h7FC0, 200);
    finish_xfer("after_reset", 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] a;
    for (int k = 0; k < 12; k++) begin
      ar_pct = $urandom_range(40, 100); r_pct = $urandom_range(40, 100); t_pct = $urandom_range(40, 100);
      t_hold = $urandom_range(0, 6);
      a = {$urandom, $urandom};
      if (k % 3 == 0) a[11:0] = 12'(4096 - 64 * $urandom_range(1, 4)) | 12'($urandom_range(0, 63));
      launch(a, (k == 5) ? 32'd0 : 32'($urandom_range(1, 6000)));
      finish_xfer("random", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_multi();
    test_4k();
    test_backpressure();
    test_zero();
    test_start_busy();
    test_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
